// File: rtl/fpu_issue_if.sv
// Request, FPU-side, write-back and CSR signals of the FP issue sequencer.
interface fpu_issue_if #(
  parameter int unsigned FLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [5:0]      req_op;
  logic [4:0]      req_rd;
  logic [2:0]      req_rm;
  logic [FLEN-1:0] req_a;
  logic [FLEN-1:0] req_b;

  logic [5:0]      fpu_op;
  logic [FLEN-1:0] fpu_rs1;
  logic [FLEN-1:0] fpu_rs2;
  logic [31:0]     fpu_fcsr;
  logic [FLEN-1:0] fpu_result;
  logic [4:0]      fpu_flags;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [FLEN-1:0] wb_data;
  logic            wb_int;
  logic            wb_illegal;

  logic            csr_we;
  logic [31:0]     csr_wdata;
  logic [31:0]     fcsr;

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_rd, req_rm, req_a, req_b,
    output req_ready,
    output fpu_op, fpu_rs1, fpu_rs2, fpu_fcsr,
    input  fpu_result, fpu_flags,
    output wb_valid, wb_rd, wb_data, wb_int, wb_illegal,
    input  wb_ready,
    input  csr_we, csr_wdata,
    output fcsr
  );

  // Core / environment side.
  modport master (
    output req_valid, req_op, req_rd, req_rm, req_a, req_b,
    input  req_ready,
    input  fpu_op, fpu_rs1, fpu_rs2, fpu_fcsr,
    output fpu_result, fpu_flags,
    input  wb_valid, wb_rd, wb_data, wb_int, wb_illegal,
    output wb_ready,
    output csr_we, csr_wdata,
    input  fcsr
  );
endinterface

// File: rtl/fpu_issue.sv
// FP issue / write-back sequencer: issues one op to a fixed-latency FPU, holds operands for
// the op's latency, captures the result for write-back and owns the architectural fcsr.
module fpu_issue #(
  parameter int unsigned FLEN     = 32,
  parameter int unsigned ADD_LAT  = 2,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned SQRT_LAT = 24
) (
  input logic         clk,
  input logic         resetn,
  fpu_issue_if.slave  bus
);

  localparam int unsigned MaxAm  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MaxDs  = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int unsigned MaxLat = (MaxAm > MaxDs) ? MaxAm : MaxDs;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      fpu_op_q, fpu_op_d;
  logic [FLEN-1:0] fpu_rs1_q, fpu_rs1_d;
  logic [FLEN-1:0] fpu_rs2_q, fpu_rs2_d;
  logic [7:0]      fpu_fcsr_q, fpu_fcsr_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [FLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_int_q, wb_int_d;
  logic            wb_illegal_q, wb_illegal_d;
  logic [4:0]      pend_q, pend_d;
  logic [2:0]      frm_q, frm_d;
  logic [4:0]      fflags_q, fflags_d;

  logic            req_ready;
  logic            wb_hs;
  logic            xfer;
  logic [2:0]      rm_res;
  logic            illegal;
  logic            op_is_int;
  logic [CntW-1:0] lat_m1;

  // Only the low byte of a CSR write is architectural.
  logic unused_csr_hi;
  assign unused_csr_hi = ^bus.csr_wdata[31:8];

  // Decode the incoming request: handshake, resolved rounding mode, legality and latency.
  always_comb begin
    req_ready = (state_q == StIdle) || ((state_q == StWb) && bus.wb_ready);
    wb_hs     = (state_q == StWb) && bus.wb_ready;
    xfer      = bus.req_valid && req_ready;
    // Dynamic rm reads fcsr as it was before any same-cycle CSR write.
    rm_res    = (bus.req_rm == 3'd7) ? frm_q : bus.req_rm;
    illegal   = (rm_res > 3'd4) || (bus.req_op > 6'd16);
    op_is_int = bus.req_op inside {6'd6, 6'd7, 6'd8, 6'd14, 6'd15, 6'd16};
    case (bus.req_op)
      6'd0:    lat_m1 = CntW'(ADD_LAT - 1);
      6'd1:    lat_m1 = CntW'(MUL_LAT - 1);
      6'd2:    lat_m1 = CntW'(DIV_LAT - 1);
      6'd3:    lat_m1 = CntW'(SQRT_LAT - 1);
      default: lat_m1 = '0;
    endcase
  end

  // Next-state logic for the sequencer FSM, issue registers, write-back and fcsr.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fpu_op_d     = fpu_op_q;
    fpu_rs1_d    = fpu_rs1_q;
    fpu_rs2_d    = fpu_rs2_q;
    fpu_fcsr_d   = fpu_fcsr_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_int_d     = wb_int_q;
    wb_illegal_d = wb_illegal_q;
    pend_d       = pend_q;
    frm_d        = frm_q;
    fflags_d     = fflags_q;

    unique case (state_q)
      StIdle: ;
      StExec: begin
        if (cnt_q == '0) begin
          wb_data_d = bus.fpu_result;
          pend_d    = bus.fpu_flags;
          state_d   = StWb;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWb: begin
        if (wb_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A transfer can only happen in IDLE or WB, so it never collides with the EXEC capture.
    if (xfer) begin
      wb_rd_d      = bus.req_rd;
      wb_int_d     = op_is_int;
      wb_illegal_d = illegal;
      wb_data_d    = '0;
      pend_d       = '0;
      if (illegal) begin
        state_d = StWb;
      end else begin
        fpu_op_d   = bus.req_op;
        fpu_rs1_d  = bus.req_a;
        fpu_rs2_d  = bus.req_b;
        fpu_fcsr_d = {rm_res, fflags_q};
        cnt_d      = lat_m1;
        state_d    = StExec;
      end
    end

    // A CSR write overrides the flags of a write-back retiring in the same cycle.
    if (bus.csr_we) begin
      frm_d    = bus.csr_wdata[7:5];
      fflags_d = bus.csr_wdata[4:0];
    end else if (wb_hs) begin
      fflags_d = fflags_q | pend_q;
    end
  end

  // State registers; reset drops any in-flight op without write-back or flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fpu_op_q     <= '0;
      fpu_rs1_q    <= '0;
      fpu_rs2_q    <= '0;
      fpu_fcsr_q   <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_int_q     <= 1'b0;
      wb_illegal_q <= 1'b0;
      pend_q       <= '0;
      frm_q        <= '0;
      fflags_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpu_op_q     <= fpu_op_d;
      fpu_rs1_q    <= fpu_rs1_d;
      fpu_rs2_q    <= fpu_rs2_d;
      fpu_fcsr_q   <= fpu_fcsr_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_int_q     <= wb_int_d;
      wb_illegal_q <= wb_illegal_d;
      pend_q       <= pend_d;
      frm_q        <= frm_d;
      fflags_q     <= fflags_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.fpu_op     = fpu_op_q;
  assign bus.fpu_rs1    = fpu_rs1_q;
  assign bus.fpu_rs2    = fpu_rs2_q;
  assign bus.fpu_fcsr   = {24'b0, fpu_fcsr_q};
  assign bus.wb_valid   = (state_q == StWb);
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_int     = wb_int_q;
  assign bus.wb_illegal = wb_illegal_q;
  assign bus.fcsr       = {24'b0, frm_q, fflags_q};

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: directed scenarios plus randomized ops against a
// transaction-level model of latency, rounding-mode resolution, legality and fcsr flags.
module tb_fpu_issue;
  localparam int unsigned FLEN     = 32;
  localparam int unsigned ADD_LAT  = 2;
  localparam int unsigned MUL_LAT  = 3;
  localparam int unsigned DIV_LAT  = 16;
  localparam int unsigned SQRT_LAT = 24;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  fpu_issue_if #(.FLEN(FLEN)) bus ();

  fpu_issue #(
    .FLEN    (FLEN),
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .SQRT_LAT(SQRT_LAT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FPU stub: result/flags change every negedge so a capture on the wrong cycle is visible.
  int unsigned cyc_n = 0;
  always @(negedge clk) cyc_n <= cyc_n + 1;

  logic        use_fixed = 1'b0;
  logic [31:0] fixed_result = '0;
  logic [4:0]  fixed_flags = '0;

  function automatic logic [31:0] stub_res(int unsigned c);
    return 32'h5A00_0000 + 32'(c);
  endfunction

  function automatic logic [4:0] stub_flg(int unsigned c);
    return 5'(c * 7);
  endfunction

  assign bus.fpu_result = use_fixed ? fixed_result : stub_res(cyc_n);
  assign bus.fpu_flags  = use_fixed ? fixed_flags : stub_flg(cyc_n);

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0]  m_fcsr = '0;
  logic [5:0]  m_op = '0;
  logic [31:0] m_rs1 = '0, m_rs2 = '0;
  logic [7:0]  m_ffcsr = '0;
  logic [2:0]  e_rm;
  logic        e_ill, e_int;
  int unsigned e_lat;

  task automatic model_xfer(input logic [5:0] op, input logic [2:0] rm,
                            input logic [31:0] a, input logic [31:0] b);
    e_rm  = (rm == 3'd7) ? m_fcsr[7:5] : rm;
    e_ill = (e_rm >= 3'd5) || (op > 6'd16);
    e_int = op inside {6'd6, 6'd7, 6'd8, 6'd14, 6'd15, 6'd16};
    if (e_ill) e_lat = 0;
    else if (op == 6'd0) e_lat = ADD_LAT;
    else if (op == 6'd1) e_lat = MUL_LAT;
    else if (op == 6'd2) e_lat = DIV_LAT;
    else if (op == 6'd3) e_lat = SQRT_LAT;
    else e_lat = 1;
    if (!e_ill) begin
      m_op = op; m_rs1 = a; m_rs2 = b; m_ffcsr = {e_rm, m_fcsr[4:0]};
    end
  endtask

  function automatic logic [31:0] exp_data(int unsigned c0);
    if (e_ill) return '0;
    return use_fixed ? fixed_result : stub_res(c0 + e_lat);
  endfunction

  function automatic logic [4:0] exp_flags(int unsigned c0);
    if (e_ill) return '0;
    return use_fixed ? fixed_flags : stub_flg(c0 + e_lat);
  endfunction

  // Drive a request and return once it has transferred (c0 = stub counter right after).
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [2:0] rm,
                      input logic [31:0] a, input logic [31:0] b,
                      output bit ok, output int unsigned c0);
    bus.req_op = op; bus.req_rd = rd; bus.req_rm = rm; bus.req_a = a; bus.req_b = b;
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    c0 = cyc_n;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    while (bus.wb_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic hs(input bit we, input logic [7:0] wd, input logic [4:0] pend);
    bus.wb_ready = 1'b1;
    bus.csr_we = we;
    bus.csr_wdata = {24'($urandom), wd};
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    bus.csr_we = 1'b0;
    if (we) m_fcsr = wd;
    else m_fcsr[4:0] = m_fcsr[4:0] | pend;
  endtask

  task automatic csr_write(input logic [7:0] wd);
    bus.csr_we = 1'b1;
    bus.csr_wdata = {24'($urandom), wd};
    @(posedge clk); #1;
    bus.csr_we = 1'b0;
    m_fcsr = wd;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_int, bus.wb_illegal} !== '0) begin
      failures++; $display("FAIL reset_wb: got v=%b rd=%0d d=%h i=%b il=%b want all 0",
                           bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_int, bus.wb_illegal);
    end
    checks++;
    if ({bus.fpu_op, bus.fpu_rs1, bus.fpu_rs2, bus.fpu_fcsr} !== '0) begin
      failures++; $display("FAIL reset_fpu: got op=%0d rs1=%h rs2=%h fcsr=%h want all 0",
                           bus.fpu_op, bus.fpu_rs1, bus.fpu_rs2, bus.fpu_fcsr);
    end
    checks++;
    if (bus.fcsr !== 32'h0) begin
      failures++; $display("FAIL reset_fcsr: got %h want 0", bus.fcsr);
    end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cvt();
    bit ok; int unsigned c0; int n;
    use_fixed = 1'b1; fixed_result = 32'h4040_0000; fixed_flags = 5'b0;
    model_xfer(6'd4, 3'd0, 32'd3, 32'd0);
    send(6'd4, 5'd7, 3'd0, 32'd3, 32'd0, ok, c0);
    wait_wb(n);
    checks++;
    if (!ok || n != 1) begin
      failures++; $display("FAIL cvt_latency: got ok=%b n=%0d want 1", ok, n);
    end
    checks++;
    if (bus.wb_data !== 32'h4040_0000) begin
      failures++; $display("FAIL cvt_data: got %h want 40400000", bus.wb_data);
    end
    checks++;
    if ({bus.wb_int, bus.wb_illegal, bus.wb_rd} !== {1'b0, 1'b0, 5'd7}) begin
      failures++; $display("FAIL cvt_wb_fields: got int=%b il=%b rd=%0d want 0 0 7",
                           bus.wb_int, bus.wb_illegal, bus.wb_rd);
    end
    checks++;
    if (bus.fpu_fcsr[7:5] !== 3'd0 || bus.fpu_rs1 !== 32'd3 || bus.fpu_op !== 6'd4) begin
      failures++; $display("FAIL cvt_fpu: got frm=%0d rs1=%h op=%0d want 0 3 4",
                           bus.fpu_fcsr[7:5], bus.fpu_rs1, bus.fpu_op);
    end
    hs(1'b0, 8'h0, exp_flags(c0));
  endtask

  task automatic test_div();
    bit ok; int unsigned c0; int n; bit stable;
    use_fixed = 1'b1; fixed_result = 32'h3F80_0000; fixed_flags = 5'b01000;
    model_xfer(6'd2, 3'd1, 32'h4000_0000, 32'h0);
    send(6'd2, 5'd12, 3'd1, 32'h4000_0000, 32'h0, ok, c0);
    n = 0; stable = 1'b1;
    while (bus.wb_valid !== 1'b1 && n < 100) begin
      if (bus.fpu_op !== 6'd2 || bus.fpu_rs1 !== 32'h4000_0000) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!ok || n != int'(DIV_LAT)) begin
      failures++; $display("FAIL div_latency: got ok=%b n=%0d want %0d", ok, n, DIV_LAT);
    end
    checks++;
    if (!stable) begin
      failures++; $display("FAIL div_fpu_stable: got unstable fpu_op/rs1 want stable");
    end
    checks++;
    if (bus.wb_data !== 32'h3F80_0000) begin
      failures++; $display("FAIL div_data: got %h want 3f800000", bus.wb_data);
    end
    hs(1'b0, 8'h0, exp_flags(c0));
    checks++;
    if (bus.fcsr !== 32'h08) begin
      failures++; $display("FAIL div_fcsr: got %h want 00000008", bus.fcsr);
    end
  endtask

  task automatic test_dyn_rm();
    bit ok; int unsigned c0; int n;
    csr_write(8'h40);
    checks++;
    if (bus.fcsr !== 32'h40) begin
      failures++; $display("FAIL csr_write: got %h want 00000040", bus.fcsr);
    end
    use_fixed = 1'b1; fixed_result = 32'h1234_5678; fixed_flags = 5'b00001;
    model_xfer(6'd9, 3'd7, 32'h1, 32'h2);
    send(6'd9, 5'd3, 3'd7, 32'h1, 32'h2, ok, c0);
    checks++;
    if (bus.fpu_fcsr !== 32'h40) begin
      failures++; $display("FAIL dyn_rm_fpu_fcsr: got %h want 00000040", bus.fpu_fcsr);
    end
    wait_wb(n);
    checks++;
    if (!ok || n != 1 || bus.wb_illegal !== 1'b0) begin
      failures++; $display("FAIL dyn_rm_wb: got ok=%b n=%0d il=%b want 1 1 0",
                           ok, n, bus.wb_illegal);
    end
    hs(1'b0, 8'h0, exp_flags(c0));
    csr_write(8'hA1);
    model_xfer(6'd9, 3'd7, 32'h5, 32'h6);
    send(6'd9, 5'd4, 3'd7, 32'h5, 32'h6, ok, c0);
    wait_wb(n);
    checks++;
    if (!ok || n != 0 || bus.wb_illegal !== 1'b1 || bus.wb_data !== 32'h0) begin
      failures++; $display("FAIL illegal_rm_wb: got ok=%b n=%0d il=%b d=%h want 1 0 1 0",
                           ok, n, bus.wb_illegal, bus.wb_data);
    end
    checks++;
    if (bus.fpu_fcsr !== {24'b0, m_ffcsr} || bus.fpu_rs1 !== m_rs1) begin
      failures++; $display("FAIL illegal_rm_fpu_hold: got fcsr=%h rs1=%h want %h %h",
                           bus.fpu_fcsr, bus.fpu_rs1, m_ffcsr, m_rs1);
    end
    hs(1'b0, 8'h0, exp_flags(c0));
    checks++;
    if (bus.fcsr !== 32'hA1) begin
      failures++; $display("FAIL illegal_rm_fcsr: got %h want 000000a1", bus.fcsr);
    end
    csr_write(8'h00);
  endtask

  task automatic test_back_to_back();
    int unsigned c0a, c0b; logic [31:0] d1; logic [4:0] p1, p2;
    use_fixed = 1'b0;
    bus.wb_ready = 1'b1;
    model_xfer(6'd14, 3'd0, 32'hAA, 32'hBB);
    bus.req_op = 6'd14; bus.req_rd = 5'd3; bus.req_rm = 3'd0;
    bus.req_a = 32'hAA; bus.req_b = 32'hBB; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    c0a = cyc_n; d1 = exp_data(c0a); p1 = exp_flags(c0a);
    model_xfer(6'd16, 3'd0, 32'hCC, 32'hDD);
    bus.req_op = 6'd16; bus.req_rd = 5'd9; bus.req_a = 32'hCC; bus.req_b = 32'hDD;
    @(posedge clk); #1;
    checks++;
    if ({bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data, bus.req_ready} !==
        {1'b1, 1'b1, 5'd3, d1, 1'b1}) begin
      failures++; $display("FAIL b2b_first_wb: got v=%b i=%b rd=%0d d=%h rr=%b want 1 1 3 %h 1",
                           bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data, bus.req_ready, d1);
    end
    @(posedge clk); #1;
    c0b = cyc_n;
    m_fcsr[4:0] = m_fcsr[4:0] | p1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.fpu_op !== 6'd16 || bus.wb_valid !== 1'b0 || bus.fcsr !== {24'b0, m_fcsr}) begin
      failures++; $display("FAIL b2b_second_issue: got op=%0d v=%b fcsr=%h want 16 0 %h",
                           bus.fpu_op, bus.wb_valid, bus.fcsr, m_fcsr);
    end
    p2 = exp_flags(c0b);
    @(posedge clk); #1;
    checks++;
    if ({bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data} !==
        {1'b1, 1'b1, 5'd9, exp_data(c0b)}) begin
      failures++; $display("FAIL b2b_second_wb: got v=%b i=%b rd=%0d d=%h want 1 1 9 %h",
                           bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data, exp_data(c0b));
    end
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    m_fcsr[4:0] = m_fcsr[4:0] | p2;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.fcsr !== {24'b0, m_fcsr}) begin
      failures++; $display("FAIL b2b_end: got v=%b fcsr=%h want 0 %h",
                           bus.wb_valid, bus.fcsr, m_fcsr);
    end
  endtask

  task automatic test_stall();
    bit ok; int unsigned c0; int n; logic [5:0] op; logic [2:0] rm;
    logic [31:0] d; logic [4:0] p; logic ei, eil; int bad;
    use_fixed = 1'b0;
    op = 6'($urandom_range(0, 16)); rm = 3'($urandom_range(0, 4));
    model_xfer(op, rm, $urandom, $urandom);
    send(op, 5'd21, rm, m_rs1, m_rs2, ok, c0);
    wait_wb(n);
    d = exp_data(c0); p = exp_flags(c0); ei = e_int; eil = e_ill;
    checks++;
    if (!ok || n != int'(e_lat)) begin
      failures++; $display("FAIL stall_first_latency: got ok=%b n=%0d want %0d", ok, n, e_lat);
    end
    bus.req_op = 6'd1; bus.req_rd = 5'd22; bus.req_rm = 3'd3;
    bus.req_a = 32'h111; bus.req_b = 32'h222; bus.req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({bus.req_ready, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_int, bus.wb_illegal} !==
          {1'b0, 1'b1, 5'd21, d, ei, eil}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
    end
    model_xfer(6'd1, 3'd3, 32'h111, 32'h222);
    bus.wb_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release_ready: got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    c0 = cyc_n;
    bus.req_valid = 1'b0; bus.wb_ready = 1'b0;
    m_fcsr[4:0] = m_fcsr[4:0] | p;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.fpu_op !== 6'd1 || bus.fcsr !== {24'b0, m_fcsr}) begin
      failures++; $display("FAIL stall_release: got v=%b op=%0d fcsr=%h want 0 1 %h",
                           bus.wb_valid, bus.fpu_op, bus.fcsr, m_fcsr);
    end
    wait_wb(n);
    checks++;
    if (n != int'(MUL_LAT) - 1 + 1 || bus.wb_data !== exp_data(c0) || bus.wb_rd !== 5'd22) begin
      failures++; $display("FAIL stall_next_op: got n=%0d d=%h rd=%0d want %0d %h 22",
                           n, bus.wb_data, bus.wb_rd, MUL_LAT, exp_data(c0));
    end
    hs(1'b0, 8'h0, exp_flags(c0));
  endtask

  task automatic test_random();
    bit ok; int unsigned c0; int n; logic [5:0] op; logic [2:0] rm; logic [4:0] rd;
    logic [31:0] a, b; bit we; logic [7:0] wd;
    use_fixed = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) csr_write(8'($urandom_range(0, 255)));
      op = 6'($urandom_range(0, 20)); rm = 3'($urandom_range(0, 7));
      rd = 5'($urandom); a = $urandom; b = $urandom;
      model_xfer(op, rm, a, b);
      send(op, rd, rm, a, b, ok, c0);
      wait_wb(n);
      checks++;
      if (!ok || n != int'(e_lat)) begin
        failures++; $display("FAIL rand_latency[%0d]: got ok=%b n=%0d want %0d op=%0d",
                             it, ok, n, e_lat, op);
      end
      checks++;
      if ({bus.wb_rd, bus.wb_int, bus.wb_illegal, bus.wb_data} !==
          {rd, e_int, e_ill, exp_data(c0)}) begin
        failures++; $display("FAIL rand_wb[%0d]: got rd=%0d i=%b il=%b d=%h want %0d %b %b %h",
                             it, bus.wb_rd, bus.wb_int, bus.wb_illegal, bus.wb_data,
                             rd, e_int, e_ill, exp_data(c0));
      end
      checks++;
      if ({bus.fpu_op, bus.fpu_rs1, bus.fpu_rs2, bus.fpu_fcsr} !==
          {m_op, m_rs1, m_rs2, 24'b0, m_ffcsr}) begin
        failures++; $display("FAIL rand_fpu[%0d]: got op=%0d rs1=%h fcsr=%h want %0d %h %h",
                             it, bus.fpu_op, bus.fpu_rs1, bus.fpu_fcsr, m_op, m_rs1, m_ffcsr);
      end
      we = ($urandom_range(0, 4) == 0);
      wd = 8'($urandom);
      hs(we, wd, exp_flags(c0));
      checks++;
      if (bus.fcsr !== {24'b0, m_fcsr} || bus.wb_valid !== 1'b0) begin
        failures++; $display("FAIL rand_fcsr[%0d]: got fcsr=%h v=%b want %h 0",
                             it, bus.fcsr, bus.wb_valid, m_fcsr);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int unsigned c0; bit seen;
    use_fixed = 1'b0;
    csr_write(8'h3F);
    model_xfer(6'd3, 3'd0, 32'h9, 32'h0);
    send(6'd3, 5'd5, 3'd0, 32'h9, 32'h0, ok, c0);
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 ||
        {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_int, bus.wb_illegal,
         bus.fpu_op, bus.fpu_rs1, bus.fpu_rs2, bus.fpu_fcsr, bus.fcsr} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs: got rr=%b v=%b op=%0d rs1=%h fcsr=%h want reset values",
                           bus.req_ready, bus.wb_valid, bus.fpu_op, bus.fpu_rs1, bus.fcsr);
    end
    @(negedge clk) resetn = 1'b1;
    m_fcsr = '0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.wb_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || bus.fcsr !== 32'h0) begin
      failures++; $display("FAIL reset_mid_after: got wb_seen=%b fcsr=%h want 0 0", seen, bus.fcsr);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rd = '0; bus.req_rm = '0;
    bus.req_a = '0; bus.req_b = '0; bus.wb_ready = 1'b0;
    bus.csr_we = 1'b0; bus.csr_wdata = '0;
    test_reset();
    test_cvt();
    test_div();
    test_dyn_rm();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fpu_issue.md
# fpu_issue

Issue and write-back sequencer on the core side of the floating-point unit. Accepts one decoded FP instruction at a time over a valid/ready handshake and drives the FPU's `operation`/`rs1`/`rs2`/`fcsr` inputs. Holds them stable for the operation's fixed latency, then captures the result and presents it on a write-back handshake. Also owns the architectural `fcsr` register: rounding-mode resolution, accrued exception flags and CSR writes.

## Interface
- `FLEN`, 32, operand/result width
- `ADD_LAT`, 2, cycles for op 0 (fadd), ≥1
- `MUL_LAT`, 3, cycles for op 1 (fmul), ≥1
- `DIV_LAT`, 16, cycles for op 2 (fdiv), ≥1
- `SQRT_LAT`, 24, cycles for op 3 (fsqrt), ≥1

Ports:
- `clk` in 1 — the single clock; all state on rising edge
- `resetn` in 1 — asynchronous, active-low reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — block can accept
- `req_op` in 6 — FPU operation code 0..16
- `req_rd` in 5 — destination register index
- `req_rm` in 3 — instruction rounding mode; 3'b111 = dynamic
- `req_a`, `req_b` in FLEN — source operands
- `fpu_op` out 6 — to FPU `operation`
- `fpu_rs1`, `fpu_rs2` out FLEN — to FPU operands
- `fpu_fcsr` out 32 — to FPU `fcsr`
- `fpu_result` in FLEN — FPU result
- `fpu_flags` in 5 — FPU exception flags {NV,DZ,OF,UF,NX}
- `wb_valid` out 1 — write-back present
- `wb_ready` in 1 — write-back consumer ready
- `wb_rd` out 5 — destination index
- `wb_data` out FLEN — result
- `wb_int` out 1 — destination is integer regfile (ops 6,7,8,14,15,16)
- `wb_illegal` out 1 — request was illegal
- `csr_we` in 1 — write `fcsr`
- `csr_wdata` in 32 — only bits [7:0] used
- `fcsr` out 32 — architectural {24'b0, frm[7:5], fflags[4:0]}

## Operation
- States: IDLE, EXEC, WB.
- `req_ready` = (state==IDLE) | (state==WB & wb_ready). A transfer occurs when `req_valid & req_ready`.
- Rounding-mode resolution: rm = (`req_rm`==7) ? `fcsr[7:5]` : `req_rm`.
- Illegal request: resolved rm ∈ {5,6,7}, or `req_op` > 16.
- Legal transfer:
  - Latch op, rd and operands into `fpu_op`/`fpu_rs1`/`fpu_rs2`.
  - Set `fpu_fcsr` = {24'b0, rm, fcsr[4:0]}.
  - Load counter with L−1, where L = ADD_LAT/MUL_LAT/DIV_LAT/SQRT_LAT for ops 0..3 and 1 for ops 4..16.
  - Go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - In the cycle the counter is 0, capture `fpu_result` into `wb_data` and `fpu_flags` into a pending-flags register; go to WB.
  - `fpu_*` outputs are constant throughout EXEC.
- Illegal transfer:
  - Skip EXEC; go directly to WB with `wb_data`=0, `wb_illegal`=1, pending flags = 0.
  - `fpu_*` outputs are not updated.
- WB:
  - `wb_valid`=1, outputs stable until `wb_ready`.
  - On handshake, OR pending flags into `fcsr[4:0]`.
  - Next state: EXEC/WB if a new transfer occurs in the same cycle, else IDLE.
- `wb_int` = op ∈ {6,7,8,14,15,16}, registered with the request.
- CSR write: when `csr_we`, `fcsr[7:0]` ← `csr_wdata[7:0]`.
  - If this coincides with a WB handshake, the CSR write wins and that op's flags are discarded.
  - `fcsr[31:8]` is always 0.
- `fpu_op`/`fpu_rs1`/`fpu_rs2`/`fpu_fcsr` hold their last values in IDLE and WB.

## Timing
- Reset (async, `resetn`=0): state IDLE, counter 0, `req_ready`=1.
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0, `wb_int`=0, `wb_illegal`=0.
  - `fpu_op`=0, `fpu_rs1`=0, `fpu_rs2`=0, `fpu_fcsr`=0, `fcsr`=0.
  - Reset mid-operation drops the in-flight op with no write-back and no flags.
- Transfer at edge t (legal, latency L): EXEC during cycles t+1..t+L; result sampled at edge t+L; `wb_valid` high from t+L.
- Illegal transfer at edge t: `wb_valid` high from t (after the edge).
- With `wb_ready` held 1 and `req_valid` held 1, legal ops issue every L+1 cycles; illegal ops issue every cycle.
- `wb_ready` low stalls indefinitely; `req_ready`=0 throughout the stall.
- The resolved rm for dynamic mode uses the `fcsr` value before any same-cycle `csr_we`.

## Test plan
- Reset, then op 4 (fcvt.s.w) with `req_a`=32'd3, rm=0 → one EXEC cycle; `wb_data`=32'h40400000, `wb_int`=0, `wb_rd` echoed, `fpu_fcsr[7:5]`=0.
- Op 2 with DIV_LAT=16, `fpu_flags`=5'b01000 (DZ) stubbed → `fpu_op` stable for 16 cycles; `wb_valid` exactly 16 cycles after the transfer edge; after the handshake `fcsr`=32'h08.
- `csr_we` with `csr_wdata`=32'h40 (frm=2), then op 9 with `req_rm`=7 → `fpu_fcsr[7:5]`=2; repeat with frm=5 → `wb_illegal`=1, `wb_data`=0, `fcsr[4:0]` unchanged.
- Back-to-back: op 14 then op 16, `wb_ready`=1, `req_valid` held → second transfer in the first's WB cycle; both write-backs with `wb_int`=1, no bubble.
- Hold `wb_ready`=0 for 10 cycles in WB with `req_valid`=1 → `req_ready`=0 and `wb_*` stable; release → single handshake, then the next op is accepted the same cycle.
- Assert `resetn`=0 mid-EXEC of op 3 → all outputs at reset values immediately; no `wb_valid` after release; `fcsr`=0.
